// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the stall-driven pipeline stages.
//   ISSUE_WIDTH : number of instruction slots per cycle (2).
//   pop_count() : turns a downstream can_proceed vector into the number of
//                 head entries consumed, limited to the entries actually valid.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int ISSUE_WIDTH = 2;

    // Number of slots consumed this cycle (0..2).
    // The result never exceeds the number of valid slots presented.
    function automatic logic [1:0] pop_count(
        input logic [1:0] can_proceed,
        input logic [1:0] valid
    );
        logic [1:0] want;
        logic [1:0] have;
        // Slot 1 may only advance together with slot 0.
        case (can_proceed)
            2'b00:   want = 2'd0;
            2'b10:   want = 2'd0;
            2'b01:   want = 2'd1;
            2'b11:   want = 2'd2;
            default: want = 2'd0;
        endcase
        // Valid slots are contiguous from slot 0. A lone slot-1 valid
        // does not make slot 1 consumable.
        case (valid)
            2'b00:   have = 2'd0;
            2'b01:   have = 2'd1;
            2'b11:   have = 2'd2;
            2'b10:   have = 2'd0;
            default: have = 2'd0;
        endcase
        if (want < have) begin
            pop_count = want;
        end else begin
            pop_count = have;
        end
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Fetch-side and decode-side handshake of the fetch queue.
//   in_valid[2], in_data[2] : fetched words; slot 0 is older
//   in_ready                : the queue can take 2 words this cycle
//   out_valid[2], out_data[2] : oldest two entries; slot 0 is oldest
//   can_proceed[2]          : downstream consume vector
// Modports:
//   slave  : the queue
//   master : the surrounding fetch/decode logic
// -----------------------------------------------------------------------------
interface fetch_queue_if
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [ISSUE_WIDTH-1:0]            in_valid;
    logic [ISSUE_WIDTH-1:0][WIDTH-1:0] in_data;
    logic                              in_ready;
    logic [ISSUE_WIDTH-1:0]            out_valid;
    logic [ISSUE_WIDTH-1:0][WIDTH-1:0] out_data;
    logic [ISSUE_WIDTH-1:0]            can_proceed;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  can_proceed
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output can_proceed
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH x WIDTH storage for the fetch queue. It has two write ports and two
// combinational read ports. The contents are not reset.
//   clk          : clock
//   we[2]        : write enables
//   waddr[2]     : write addresses (never equal while both enables are set)
//   wdata[2]     : write data
//   raddr[2]     : read addresses
//   rdata[2]     : read data (combinational)
// -----------------------------------------------------------------------------
module fetch_queue_mem
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic [ISSUE_WIDTH-1:0]            we,
    input  logic [ISSUE_WIDTH-1:0][PTR_W-1:0] waddr,
    input  logic [ISSUE_WIDTH-1:0][WIDTH-1:0] wdata,
    input  logic [ISSUE_WIDTH-1:0][PTR_W-1:0] raddr,
    output logic [ISSUE_WIDTH-1:0][WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write ports: the queue always targets tail and tail+1, so they never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (we[i]) begin
                mem_r[waddr[i]] <= wdata[i];
            end
        end
    end

    // Read ports: the head entries, available in the same cycle.
    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rdata[i] = mem_r[raddr[i]];
        end
    end

endmodule

// File: rtl/flop_r.sv
// -----------------------------------------------------------------------------
// flop_r
// Resettable enabled register with a synchronous active-high reset.
//   clk, reset : clock, synchronous reset (loads RESET_VAL)
//   en         : load enable
//   d, q       : data in, registered data out
// -----------------------------------------------------------------------------
module flop_r #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register: reset wins over the load enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Dual-slot instruction buffer in front of the 2-wide decode register.
// It accepts up to two fetched words per cycle. It presents the oldest two
// entries in program order and consumes them according to can_proceed.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empty the queue on a branch redirect
//   bus          : fetch_queue_if.slave (in_valid/in_data/in_ready,
//                  out_valid/out_data, can_proceed)
//   occupancy    : registered entry count
//   stall_cycles : only when FETCH_QUEUE_STATS_EN is defined; a saturating
//                  count of cycles with a valid head and !can_proceed[0]
// Optional feature macro: FETCH_QUEUE_STATS_EN
// -----------------------------------------------------------------------------
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    fetch_queue_if.slave     bus,
    output logic [CNT_W-1:0] occupancy
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;

    logic                              in_ready_s;
    logic [ISSUE_WIDTH-1:0]            out_valid_s;
    logic [1:0]                        push_n_s;
    logic [1:0]                        pop_n_s;
    logic [ISSUE_WIDTH-1:0]            we_s;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] waddr_s;
    logic [ISSUE_WIDTH-1:0][WIDTH-1:0] wdata_s;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] raddr_s;
    logic [ISSUE_WIDTH-1:0][WIDTH-1:0] rdata_s;

    // Status from registered count only; no path from can_proceed to in_ready.
    always_comb begin
        in_ready_s     = (count_r <= CNT_W'(DEPTH - 2));
        out_valid_s[0] = (count_r >= CNT_W'(2'd1));
        out_valid_s[1] = (count_r >= CNT_W'(2'd2));
    end

    // Push/pop amounts and storage write steering. A lone slot-1 word
    // goes to tail, so the stored order is always dense.
    always_comb begin
        push_n_s   = 2'd0;
        we_s       = 2'b00;
        waddr_s[0] = tail_r;
        waddr_s[1] = tail_r + PTR_W'(1'b1);
        wdata_s[0] = bus.in_data[0];
        wdata_s[1] = bus.in_data[1];
        if (in_ready_s) begin
            push_n_s = {1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]};
        end else begin
            push_n_s = 2'd0;
        end
        if (bus.in_valid[0]) begin
            wdata_s[0] = bus.in_data[0];
        end else begin
            wdata_s[0] = bus.in_data[1];
        end
        if (in_ready_s && !flush && !reset) begin
            we_s[0] = (push_n_s != 2'd0);
            we_s[1] = (push_n_s == 2'd2);
        end else begin
            we_s = 2'b00;
        end
        pop_n_s = pop_count(bus.can_proceed, out_valid_s);
    end

    // Next pointer/count state. Flush discards the pushes and pops of the same cycle.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            head_nxt_s  = {PTR_W{1'b0}};
            tail_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            head_nxt_s  = head_r + PTR_W'(pop_n_s);
            tail_nxt_s  = tail_r + PTR_W'(push_n_s);
            count_nxt_s = count_r + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
        end
    end

    flop_r #(.WIDTH(PTR_W)) u_head_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (head_nxt_s),
        .q     (head_r)
    );

    flop_r #(.WIDTH(PTR_W)) u_tail_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (tail_nxt_s),
        .q     (tail_r)
    );

    flop_r #(.WIDTH(CNT_W)) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (count_nxt_s),
        .q     (count_r)
    );

    // Read addresses are head and head+1; the +1 wraps modulo DEPTH.
    always_comb begin
        raddr_s[0] = head_r;
        raddr_s[1] = head_r + PTR_W'(1'b1);
    end

    fetch_queue_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Drive the handshake outputs. Data of slots that are not valid reads as zero.
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.out_valid = out_valid_s;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (out_valid_s[i]) begin
                bus.out_data[i] = rdata_s[i];
            end else begin
                bus.out_data[i] = {WIDTH{1'b0}};
            end
        end
        occupancy = count_r;
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_r;
    logic [31:0] stall_nxt_s;

    // Count head-stall cycles and saturate. Only reset clears the counter.
    always_comb begin
        stall_nxt_s = stall_r;
        if (out_valid_s[0] && !bus.can_proceed[0] && (stall_r != 32'hFFFF_FFFF)) begin
            stall_nxt_s = stall_r + 32'd1;
        end else begin
            stall_nxt_s = stall_r;
        end
    end

    flop_r #(.WIDTH(32)) u_stall_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (stall_nxt_s),
        .q     (stall_r)
    );

    assign stall_cycles = stall_r;
`endif

endmodule
